// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit core: frame geometry defaults and
// the transmitter state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int PERIOD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
// each bit held for a run-time programmable number of clock cycles.
module uart_tx_core #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS,
    parameter int PERIOD_W  = uart_pkg::PERIOD_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  tx_start,
    input  logic [DATA_BITS-1:0]  tx_data,
    output logic                  txd,
    output logic                  tx_avai,
    output uart_pkg::tx_state_e   state_dbg
);
    import uart_pkg::*;

    // Handshake: tx_start is the valid pulse and tx_avai the ready flag. A byte
    // is taken on a rising edge where both are 1 and reset is 0; a tx_start
    // seen while tx_avai is 0 is dropped, never queued.

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [2:0]          LAST_IDX   = 3'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   txd_q, txd_d;
    logic                   bit_done;

    // period_q is never 0 outside IDLE, so the subtraction cannot wrap there.
    assign bit_done = (cnt_q == (period_q - PERIOD_ONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        idx_d    = idx_q;
        data_d   = data_q;
        txd_d    = txd_q;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                idx_d = '0;
                if (tx_start) begin
                    state_d  = ST_START;
                    data_d   = tx_data;
                    period_d = (period == '0) ? PERIOD_ONE : period;
                    txd_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    txd_d   = data_q[0];
                end else begin
                    cnt_d = cnt_q + PERIOD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = data_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_ONE;
                end
            end
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // txd comes straight from a flop; the next line level is decided one cycle early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            txd_q    <= txd_d;
        end
    end

    assign txd       = txd_q;
    assign tx_avai   = (state_q == ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: a frame-level reference model expands
// each accepted byte into its expected per-cycle line waveform.
module tb_uart_tx_core;
    import uart_pkg::*;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] period   = 16'd4;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data  = 8'h00;
    logic        txd;
    logic        tx_avai;
    tx_state_e   state_dbg;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected {tx_avai, txd} for each upcoming busy cycle; empty means idle.
    logic [1:0] exp_q[$];

    uart_tx_core dut (
        .clk       (clk),
        .reset     (reset),
        .period    (period),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .txd       (txd),
        .tx_avai   (tx_avai),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin : model
        int         p;
        bit         was_idle;
        logic [9:0] frame;
        if (reset) begin
            exp_q.delete();
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) begin
                void'(exp_q.pop_front());
            end else if (tx_start) begin
                p     = (period == 16'd0) ? 1 : int'(period);
                frame = {1'b1, tx_data, 1'b0};
                for (int b = 0; b < 10; b++)
                    for (int c = 0; c < p; c++)
                        exp_q.push_back({1'b0, frame[b]});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [1:0] e;
        if (chk_en) begin
            e = (exp_q.size() != 0) ? exp_q[0] : 2'b11;
            check("model_line", 32'({tx_avai, txd}), 32'(e));
        end
    end

    // ---------------- driver tasks (all driving on negedge) ----------------
    task automatic send(input logic [7:0] d, input logic [15:0] p, input bit now);
        if (!now) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        period   = p;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Called in the first busy cycle; returns at the negedge where tx_avai is
    // back. Samples each bit at its centre and measures the initial low run.
    task automatic wait_frame(input int p, input int bound, input int inj_at,
                              input logic [7:0] inj_data,
                              output int n, output logic [9:0] bits, output int low_run);
        n = 0; bits = '0; low_run = 0;
        while (!tx_avai && n < bound) begin
            if ((n % p) == (p / 2) && (n / p) < 10) bits[n / p] = txd;
            if (txd == 1'b0 && low_run == n) low_run++;
            if (n == inj_at) begin
                tx_start = 1'b1;
                tx_data  = inj_data;
            end else begin
                tx_start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        if (n >= bound) $display("FAIL wait_frame_timeout: got %0d cycles required under %0d", n, bound);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         n, low_run, gap, abort_at;
        logic [9:0] bits;
        logic [7:0] d;
        logic [15:0] p;
        int         pi;

        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_avai", 32'(tx_avai), 32'd1);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", 32'({tx_avai, txd}), 32'd3);
        end

        // 0xB5 at period 4
        send(8'hB5, 16'd4, 1'b0);
        wait_frame(4, 200, -1, 8'h00, n, bits, low_run);
        check("b5_busy_cycles", 32'(n), 32'd40);
        check("b5_bits", 32'(bits), 32'(10'b1101101010));
        check("b5_start_low", 32'(low_run), 32'd4);

        // Busy-time tx_start with 0x00 at cycle 10 is ignored
        send(8'hB5, 16'd4, 1'b0);
        wait_frame(4, 200, 10, 8'h00, n, bits, low_run);
        check("ignore_busy_cycles", 32'(n), 32'd40);
        check("ignore_busy_bits", 32'(bits), 32'(10'b1101101010));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("ignore_no_second", 32'(tx_avai), 32'd1);
        end

        // Back-to-back at period 3: 0x01 then 0x80
        send(8'h01, 16'd3, 1'b0);
        wait_frame(3, 200, -1, 8'h00, n, bits, low_run);
        check("b2b_first_cycles", 32'(n), 32'd30);
        check("b2b_first_bits", 32'(bits), 32'(10'b1000000010));
        send(8'h80, 16'd3, 1'b1);
        wait_frame(3, 200, -1, 8'h00, n, bits, low_run);
        check("b2b_second_cycles", 32'(n), 32'd30);
        check("b2b_second_bits", 32'(bits), 32'(10'b1100000000));

        // Reset at cycle 15 of a period-4 frame, with tx_start held during reset
        send(8'hB5, 16'd4, 1'b0);
        repeat (15) @(negedge clk);
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        reset    = 1'b0;
        tx_start = 1'b0;
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_avai", 32'(tx_avai), 32'd1);
        @(negedge clk);
        check("abort_start_ignored", 32'(tx_avai), 32'd1);
        send(8'h3C, 16'd4, 1'b0);
        wait_frame(4, 200, -1, 8'h00, n, bits, low_run);
        check("after_abort_cycles", 32'(n), 32'd40);
        check("after_abort_bits", 32'(bits), 32'(10'b1001111000));

        // Period 0 clamps to 1
        send(8'hA5, 16'd0, 1'b0);
        wait_frame(1, 50, -1, 8'h00, n, bits, low_run);
        check("clamp_cycles", 32'(n), 32'd10);
        check("clamp_bits", 32'(bits), 32'(10'b1101001010));

        // Randomized frames: busy-time noise on all inputs, occasional aborts
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            d  = 8'($urandom);
            pi = $urandom_range(0, 5);
            p  = 16'(pi);
            send(d, p, (gap == 0));
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
            n = 0;
            while (!tx_avai && n < 100) begin
                tx_start = ($urandom_range(0, 7) == 0);
                tx_data  = 8'($urandom);
                period   = 16'($urandom_range(0, 9));
                reset    = (n == abort_at);
                n++;
                @(negedge clk);
            end
            reset    = 1'b0;
            tx_start = 1'b0;
            check("rand_frame_done", 32'(tx_avai), 32'd1);
        end

        // Long period: start 2 cycles after reset release
        do_reset();
        @(negedge clk);
        send(8'hB5, 16'd5208, 1'b0);
        wait_frame(5208, 60000, -1, 8'h00, n, bits, low_run);
        check("slow_start_low", 32'(low_run), 32'd5208);
        check("slow_frame_cycles", 32'(n), 32'd52080);
        check("slow_bits", 32'(bits), 32'(10'b1101101010));

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame (fixed at 8 for this block).
REQ-002 Parameter: PERIOD_W, 16, width of the bit-period input.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 period  input  PERIOD_W  clock cycles per UART bit; 5208 gives 9600 baud at 50 MHz.
REQ-007 tx_start  input  1  single-cycle request to send tx_data.
REQ-008 tx_data  input  8  byte to send.
REQ-009 txd  output  1  serial line, idle high.
REQ-010 tx_avai  output  1  high when idle and able to accept tx_start.

Function
REQ-011 States SHALL be IDLE, START, DATA and STOP.
REQ-012 In IDLE, txd SHALL be 1 and tx_avai SHALL be 1; in every other state tx_avai SHALL be 0.
REQ-013 tx_start=1 sampled in IDLE SHALL latch tx_data, and latch period clamped to a minimum of 1.
REQ-014 Sampling tx_start=1 in IDLE SHALL enter START, so txd=0 from the next cycle.
REQ-015 tx_start while not IDLE SHALL be ignored; the in-flight frame and its latched data/period SHALL be unaffected.
REQ-016 Changes on tx_data or period after the latch SHALL not affect the current frame.
REQ-017 START SHALL drive txd=0 for exactly period_latched cycles.
REQ-018 DATA SHALL send the 8 bits LSB first, each held for exactly period_latched cycles; a 3-bit index SHALL count 0..7.
REQ-019 STOP SHALL drive txd=1 for period_latched cycles, then enter IDLE.
REQ-020 A frame SHALL occupy exactly 10*period_latched cycles from the first txd=0 cycle to the first tx_avai=1 cycle.
REQ-021 tx_start arriving in the same cycle IDLE is re-entered SHALL be accepted, giving back-to-back frames with no extra idle cycle.
REQ-022 The bit-period counter SHALL count 0..period_latched-1 and wrap; it SHALL be PERIOD_W bits wide, with no overflow for period up to 2^PERIOD_W-1.
REQ-023 txd SHALL be a registered output with no combinational glitches.

Reset
REQ-024 reset=1 SHALL force IDLE, txd=1, tx_avai=1, counters=0 and latched data=0 at the next rising edge.
REQ-025 Reset mid-frame SHALL abort the frame, and the line SHALL return high on the next cycle.
REQ-026 tx_start asserted during reset SHALL be ignored.

Structure
REQ-027 The state enum and the DATA_BITS and PERIOD_W constants SHALL live in a shared package, uart_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the bit-period counter is inline.

Verification
REQ-029 Reset, then hold idle for 20 cycles -> txd=1, tx_avai=1 throughout.
REQ-030 period=4, tx_data=0xB5, 1-cycle tx_start -> txd sequence 0,1,0,1,0,1,1,0,1,1, each level for 4 cycles; tx_avai=0 for 40 cycles, then 1.
REQ-031 period=5208, tx_data=0xB5, start 2 cycles after reset release -> start bit low for 5208 cycles; full frame 52080 cycles.
REQ-032 period=4; pulse tx_start again at cycle 10 of a frame with tx_data=0x00 -> the frame still carries 0xB5, and no second frame follows.
REQ-033 period=3; assert tx_start in the cycle tx_avai rises; tx_data=0x01 then 0x80 -> the second start bit follows the first stop bit immediately; the bits decode to 0x01 then 0x80.
REQ-034 Reset asserted at cycle 15 of a period=4 frame -> txd=1 and tx_avai=1 the next cycle; a new tx_start then sends a full correct frame.
